// File: rtl/axi_master_arbiter_if.sv
// rtl/axi_master_arbiter_if.sv - request, bus handshake and select bundle for the N:1 AXI master arbiter
interface axi_master_arbiter_if #(
    parameter int M_WIDTH = 2
);
    localparam int N = 1 << M_WIDTH;

    logic [N-1:0]       m_wr_req;
    logic [N-1:0]       m_rd_req;
    logic               bus_wr_addr_valid;
    logic               bus_wr_addr_ready;
    logic               bus_wr_data_valid;
    logic               bus_wr_data_ready;
    logic               bus_wr_data_last;
    logic               bus_wr_back_valid;
    logic               bus_wr_back_ready;
    logic               bus_rd_addr_valid;
    logic               bus_rd_addr_ready;
    logic               bus_rd_data_valid;
    logic               bus_rd_data_ready;
    logic               bus_rd_data_last;
    logic [M_WIDTH-1:0] wr_addr_sel;
    logic [M_WIDTH-1:0] wr_data_sel;
    logic [M_WIDTH-1:0] wr_resp_sel;
    logic [M_WIDTH-1:0] rd_addr_sel;
    logic [M_WIDTH-1:0] rd_data_sel;
    logic               wr_busy;
    logic               rd_busy;

    modport slave (
        input  m_wr_req, m_rd_req,
        input  bus_wr_addr_valid, bus_wr_addr_ready,
        input  bus_wr_data_valid, bus_wr_data_ready, bus_wr_data_last,
        input  bus_wr_back_valid, bus_wr_back_ready,
        input  bus_rd_addr_valid, bus_rd_addr_ready,
        input  bus_rd_data_valid, bus_rd_data_ready, bus_rd_data_last,
        output wr_addr_sel, wr_data_sel, wr_resp_sel,
        output rd_addr_sel, rd_data_sel,
        output wr_busy, rd_busy
    );

    modport master (
        output m_wr_req, m_rd_req,
        output bus_wr_addr_valid, bus_wr_addr_ready,
        output bus_wr_data_valid, bus_wr_data_ready, bus_wr_data_last,
        output bus_wr_back_valid, bus_wr_back_ready,
        output bus_rd_addr_valid, bus_rd_addr_ready,
        output bus_rd_data_valid, bus_rd_data_ready, bus_rd_data_last,
        input  wr_addr_sel, wr_data_sel, wr_resp_sel,
        input  rd_addr_sel, rd_data_sel,
        input  wr_busy, rd_busy
    );
endinterface

// File: rtl/axi_master_arbiter.sv
// rtl/axi_master_arbiter.sv - independent round-robin write/read path owner for the N:1 AXI master switch
module axi_master_arbiter #(
    parameter int M_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    axi_master_arbiter_if.slave   arb
);
    localparam int N = 1 << M_WIDTH;

    typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

    w_state_t           w_state, w_next;
    r_state_t           r_state, r_next;
    logic [M_WIDTH-1:0] wr_grant_q, wr_grant_d, wr_ptr, wr_ptr_d, wr_win, wr_sel;
    logic [M_WIDTH-1:0] rd_grant_q, rd_grant_d, rd_ptr, rd_ptr_d, rd_win, rd_sel;
    logic               aw_done, aw_done_d, w_done, w_done_d;
    logic               aw_hs, wl_hs, b_hs, ar_hs, rl_hs;

    // Lowest offset from ptr wins: scan downward so the last hit is the nearest one.
    function automatic logic [M_WIDTH-1:0] rr_pick(input logic [N-1:0] req,
                                                   input logic [M_WIDTH-1:0] ptr);
        logic [M_WIDTH-1:0] idx;
        rr_pick = ptr;
        for (int i = N - 1; i >= 0; i--) begin
            idx = ptr + M_WIDTH'(i);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

    assign aw_hs = arb.bus_wr_addr_valid & arb.bus_wr_addr_ready;
    assign wl_hs = arb.bus_wr_data_valid & arb.bus_wr_data_ready & arb.bus_wr_data_last;
    assign b_hs  = arb.bus_wr_back_valid & arb.bus_wr_back_ready;
    assign ar_hs = arb.bus_rd_addr_valid & arb.bus_rd_addr_ready;
    assign rl_hs = arb.bus_rd_data_valid & arb.bus_rd_data_ready & arb.bus_rd_data_last;

    assign wr_win = rr_pick(arb.m_wr_req, wr_ptr);
    assign rd_win = rr_pick(arb.m_rd_req, rd_ptr);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state    <= W_IDLE;
            r_state    <= R_IDLE;
            wr_grant_q <= '0;
            rd_grant_q <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            w_state    <= w_next;
            r_state    <= r_next;
            wr_grant_q <= wr_grant_d;
            rd_grant_q <= rd_grant_d;
            wr_ptr     <= wr_ptr_d;
            rd_ptr     <= rd_ptr_d;
            aw_done    <= aw_done_d;
            w_done     <= w_done_d;
        end
    end

    always_comb begin
        w_next     = w_state;
        wr_grant_d = wr_grant_q;
        wr_ptr_d   = wr_ptr;
        aw_done_d  = aw_done;
        w_done_d   = w_done;
        wr_sel     = wr_grant_q;
        case (w_state)
            W_IDLE: begin
                if (|arb.m_wr_req) begin
                    wr_sel     = wr_win;
                    wr_grant_d = wr_win;
                    wr_ptr_d   = wr_win + 1'b1;
                    if (aw_hs && wl_hs) begin
                        w_next = W_RESP;
                    end else begin
                        w_next    = W_XFER;
                        aw_done_d = aw_hs;
                        w_done_d  = wl_hs;
                    end
                end
            end
            W_XFER: begin
                aw_done_d = aw_done | aw_hs;
                w_done_d  = w_done | wl_hs;
                if (aw_done_d && w_done_d) w_next = W_RESP;
            end
            W_RESP: begin
                if (b_hs) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next     = r_state;
        rd_grant_d = rd_grant_q;
        rd_ptr_d   = rd_ptr;
        rd_sel     = rd_grant_q;
        case (r_state)
            R_IDLE: begin
                if (|arb.m_rd_req) begin
                    rd_sel     = rd_win;
                    rd_grant_d = rd_win;
                    rd_ptr_d   = rd_win + 1'b1;
                    r_next     = ar_hs ? R_DATA : R_ADDR;
                end
            end
            R_ADDR: begin
                if (ar_hs) r_next = R_DATA;
            end
            R_DATA: begin
                if (rl_hs) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    assign arb.wr_addr_sel = wr_sel;
    assign arb.wr_data_sel = wr_sel;
    assign arb.wr_resp_sel = wr_sel;
    assign arb.rd_addr_sel = rd_sel;
    assign arb.rd_data_sel = rd_sel;
    assign arb.wr_busy     = (w_state != W_IDLE);
    assign arb.rd_busy     = (r_state != R_IDLE);
endmodule

// File: tb/tb_axi_master_arbiter.sv
// tb/tb_axi_master_arbiter.sv - vector-table and scoreboard bench for axi_master_arbiter
module tb_axi_master_arbiter;
    localparam int MW = 2;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    axi_master_arbiter_if #(.M_WIDTH(MW)) arb_if ();

    axi_master_arbiter #(.M_WIDTH(MW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .arb  (arb_if.slave)
    );

    // aw/w/b/ar/r fields are {valid, ready}; wl/rl are the last flags.
    typedef struct {
        logic [3:0] wr_req;
        logic [1:0] aw, w, b;
        logic       wl;
        logic [3:0] rd_req;
        logic [1:0] ar, r;
        logic       rl;
        logic [1:0] ews, ers;
        logic       ewb, erb;
    } vec_t;

    vec_t       tbl[$];
    logic [3:0] sel_q[$];
    logic [1:0] busy_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    function automatic vec_t mk(int wr_req, int aw, int w, int wl, int b,
                                int rd_req, int ar, int r, int rl,
                                int ews, int ers, int ewb, int erb);
        vec_t v;
        v.wr_req = 4'(wr_req); v.aw = 2'(aw); v.w = 2'(w); v.wl = 1'(wl); v.b = 2'(b);
        v.rd_req = 4'(rd_req); v.ar = 2'(ar); v.r = 2'(r); v.rl = 1'(rl);
        v.ews = 2'(ews); v.ers = 2'(ers); v.ewb = 1'(ewb); v.erb = 1'(erb);
        return v;
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s #%0d: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        arb_if.m_wr_req          = v.wr_req;
        arb_if.bus_wr_addr_valid = v.aw[1];
        arb_if.bus_wr_addr_ready = v.aw[0];
        arb_if.bus_wr_data_valid = v.w[1];
        arb_if.bus_wr_data_ready = v.w[0];
        arb_if.bus_wr_data_last  = v.wl;
        arb_if.bus_wr_back_valid = v.b[1];
        arb_if.bus_wr_back_ready = v.b[0];
        arb_if.m_rd_req          = v.rd_req;
        arb_if.bus_rd_addr_valid = v.ar[1];
        arb_if.bus_rd_addr_ready = v.ar[0];
        arb_if.bus_rd_data_valid = v.r[1];
        arb_if.bus_rd_data_ready = v.r[0];
        arb_if.bus_rd_data_last  = v.rl;
    endtask

    task automatic check_sels(string name, int idx, logic [1:0] ews, logic [1:0] ers);
        chk({name, ".wr_sel"}, idx,
            32'({arb_if.wr_addr_sel, arb_if.wr_data_sel, arb_if.wr_resp_sel}), 32'({ews, ews, ews}));
        chk({name, ".rd_sel"}, idx,
            32'({arb_if.rd_addr_sel, arb_if.rd_data_sel}), 32'({ers, ers}));
    endtask

    task automatic check_busy(string name, int idx, logic ewb, logic erb);
        chk({name, ".wr_busy"}, idx, 32'(arb_if.wr_busy), 32'(ewb));
        chk({name, ".rd_busy"}, idx, 32'(arb_if.rd_busy), 32'(erb));
    endtask

    // Called just after a rising edge: selects are checked before the next edge,
    // busy flags just after it.
    task automatic step(string name, int idx, vec_t v);
        logic [3:0] es;
        logic [1:0] eb;
        drive(v);
        sel_q.push_back({v.ews, v.ers});
        busy_q.push_back({v.ewb, v.erb});
        #4;
        es = sel_q.pop_front();
        check_sels(name, idx, es[3:2], es[1:0]);
        @(posedge clk);
        #1;
        eb = busy_q.pop_front();
        check_busy(name, idx, eb[1], eb[0]);
    endtask

    initial begin
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        check_sels("reset", 0, 2'd0, 2'd0);
        check_busy("reset", 0, 1'b0, 1'b0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Write path: single beat, round robin 0..3..0, W-last ahead of AW, wrap.
        tbl.push_back(mk(4'b0001, 3, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(4'b1111, 3, 3, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(4'b1111, 0, 0, 0, 3, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(4'b1111, 3, 3, 1, 0, 0, 0, 0, 0, 2, 0, 1, 0));
        tbl.push_back(mk(4'b1111, 0, 0, 0, 3, 0, 0, 0, 0, 2, 0, 0, 0));
        tbl.push_back(mk(4'b1111, 3, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1, 0));
        tbl.push_back(mk(4'b1111, 0, 3, 0, 0, 0, 0, 0, 0, 3, 0, 1, 0));
        tbl.push_back(mk(4'b1111, 0, 3, 1, 0, 0, 0, 0, 0, 3, 0, 1, 0));
        tbl.push_back(mk(4'b1111, 0, 0, 0, 3, 0, 0, 0, 0, 3, 0, 0, 0));
        tbl.push_back(mk(4'b1111, 3, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(4'b0010, 0, 3, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 3, 0, 0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(4'b0000, 2, 0, 0, 3, 0, 0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(4'b0000, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 3, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(4'b0101, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0));
        tbl.push_back(mk(4'b0000, 3, 3, 1, 0, 0, 0, 0, 0, 2, 0, 1, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 3, 0, 0, 0, 0, 2, 0, 0, 0));
        tbl.push_back(mk(4'b0011, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(4'b0000, 3, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        // Read path: 4-beat burst on master 2 with the request moving to master 1 mid-burst.
        tbl.push_back(mk(0, 0, 0, 0, 0, 4'b0100, 3, 0, 0, 0, 2, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4'b0010, 0, 3, 0, 0, 2, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4'b0010, 0, 3, 0, 0, 2, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4'b0010, 0, 2, 1, 0, 2, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4'b0010, 0, 3, 0, 0, 2, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4'b0010, 0, 3, 1, 0, 2, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4'b0010, 0, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4'b0010, 2, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 3, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 0, 3, 1, 0, 1, 0, 0));
        // Both paths on master 1, B and RLAST in the same cycle.
        tbl.push_back(mk(4'b0010, 3, 3, 1, 0, 4'b0010, 3, 0, 0, 1, 1, 1, 1));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 3, 4'b0000, 0, 3, 1, 1, 1, 0, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 1, 1, 0, 0));

        for (int i = 0; i < tbl.size(); i++) step("vec", i, tbl[i]);

        // Reset while write is in W_XFER and read is in R_ADDR.
        step("pre_rst", 0, mk(4'b0100, 3, 0, 0, 0, 4'b1000, 0, 0, 0, 2, 3, 1, 1));
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        check_sels("idle_pre_rst", 0, 2'd2, 2'd3);
        rstn = 1'b0;
        #1;
        check_sels("async_rst", 0, 2'd0, 2'd0);
        check_busy("async_rst", 0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        step("post_rst", 0, mk(4'b1111, 0, 0, 0, 0, 4'b1111, 0, 0, 0, 0, 0, 1, 1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
